// File: rtl/acc_sequencer.sv
// Control sequencer for the 16-bit accumulator datapath: fetch, decode, memory/input
// handshakes, and ALU select / accumulator write-strobe generation.
module acc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr_rdata,
    output logic            data_req,
    output logic [7:0]      data_addr,
    input  logic            data_valid,
    input  logic            in_valid,
    output logic            in_ack,
    output logic [2:0]      asel0,
    output logic [2:0]      asel1,
    output logic            acc_src,
    output logic            acc_we,
    output logic [7:0]      imm,
    output logic [3:0]      reg_sel,
    output logic            halt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_WAIT_IN,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDM = 4'h2;
    localparam logic [3:0] OP_IN  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      opcode;

    assign opcode     = ir[15:12];
    assign instr_addr = pc;
    assign data_addr  = ir[7:0];
    assign imm        = ir[7:0];
    assign reg_sel    = ir[11:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            asel0   <= '0;
            asel1   <= '0;
            acc_src <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid) begin
                ir <= instr_rdata;
                pc <= pc + 1'b1;
            end
            // Opcodes 1..8 drive out1, 9..E drive out2; the other select field is left untouched.
            if (state == S_DECODE) begin
                if (opcode >= 4'h1 && opcode <= 4'h8) begin
                    asel0   <= 3'(opcode - 4'h1);
                    acc_src <= 1'b0;
                end else if (opcode >= 4'h9 && opcode <= 4'hE) begin
                    asel1   <= 3'(opcode - 4'h9);
                    acc_src <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        data_req  = 1'b0;
        in_ack    = 1'b0;
        acc_we    = 1'b0;
        halt      = 1'b0;
        case (state)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:  state_nxt = S_FETCH;
                    OP_LDM:  state_nxt = S_MEM;
                    OP_IN:   state_nxt = S_WAIT_IN;
                    OP_HLT:  state_nxt = S_HALT;
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_MEM: begin
                data_req = 1'b1;
                if (data_valid) state_nxt = S_EXEC;
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    in_ack    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_we    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
        // Reset abandons any handshake in flight, so no strobe may escape during it.
        if (rst) begin
            instr_req = 1'b0;
            data_req  = 1'b0;
            in_ack    = 1'b0;
            acc_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed scenarios plus a random program
// checked against an instruction-level reference model.
module tb_acc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_rdata;
    logic        data_req;
    logic [7:0]  data_addr;
    logic        data_valid;
    logic        in_valid;
    logic        in_ack;
    logic [2:0]  asel0;
    logic [2:0]  asel1;
    logic        acc_src;
    logic        acc_we;
    logic [7:0]  imm;
    logic [3:0]  reg_sel;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state visible at instruction granularity.
    logic [7:0] m_pc;
    logic [2:0] m_asel0;
    logic [2:0] m_asel1;
    logic       m_src;

    acc_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_valid(data_valid),
        .in_valid(in_valid), .in_ack(in_ack),
        .asel0(asel0), .asel1(asel1), .acc_src(acc_src), .acc_we(acc_we),
        .imm(imm), .reg_sel(reg_sel), .halt(halt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_exec(input logic [15:0] w);
        int op;
        op = int'(w[15:12]);
        m_pc = m_pc + 8'd1;
        if (op >= 1 && op <= 8) begin
            m_asel0 = 3'(op - 1);
            m_src   = 1'b0;
        end else if (op >= 9 && op <= 14) begin
            m_asel1 = 3'(op - 9);
            m_src   = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b1; data_valid = 1'b1; in_valid = 1'b1; instr_rdata = 16'h3A5C;
        step(); step();
        n_checks++;
        if ({instr_req, data_req, in_ack, acc_we} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes got=%b want=0000", {instr_req, data_req, in_ack, acc_we});
        end
        instr_valid = 1'b0; data_valid = 1'b0; in_valid = 1'b0;
        rst = 1'b0;
        m_pc = 8'h00; m_asel0 = 3'd0; m_asel1 = 3'd0; m_src = 1'b0;
        step();
        n_checks++;
        if ({instr_req, instr_addr, asel0, asel1, acc_src, halt, imm, reg_sel} !== {1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state req=%b addr=%h asel0=%0d asel1=%0d src=%b halt=%b imm=%h reg=%h want req=1 rest 0",
                     instr_req, instr_addr, asel0, asel1, acc_src, halt, imm, reg_sel);
        end
    endtask

    // Runs one complete instruction with the given handshake wait counts, injecting
    // stray valids outside their own states, and checks every phase against the model.
    task automatic run_instr(input logic [15:0] w, input int iwait, input int dwait, input int inwait);
        logic [3:0] op;
        op = w[15:12];
        n_checks++;
        if (instr_req !== 1'b1 || instr_addr !== m_pc || halt !== 1'b0) begin
            n_fail++; $display("FAIL fetch req=%b addr=%h halt=%b want req=1 addr=%h halt=0", instr_req, instr_addr, halt, m_pc);
        end
        for (int i = 0; i < iwait; i++) begin
            instr_valid = 1'b0; data_valid = 1'($urandom % 2); in_valid = 1'($urandom % 2);
            step();
            n_checks++;
            if (instr_req !== 1'b1 || instr_addr !== m_pc || acc_we !== 1'b0 || in_ack !== 1'b0) begin
                n_fail++; $display("FAIL fetch_wait req=%b addr=%h we=%b ack=%b want 1 %h 0 0", instr_req, instr_addr, acc_we, in_ack, m_pc);
            end
        end
        instr_valid = 1'b1; instr_rdata = w; data_valid = 1'b0; in_valid = 1'b0;
        step();
        instr_valid = 1'b0; instr_rdata = 16'($urandom);
        model_exec(w);
        n_checks++;
        if (instr_req !== 1'b0 || acc_we !== 1'b0 || reg_sel !== w[11:8] || imm !== w[7:0]) begin
            n_fail++; $display("FAIL decode req=%b we=%b reg=%h imm=%h want 0 0 %h %h", instr_req, acc_we, reg_sel, imm, w[11:8], w[7:0]);
        end
        step();
        if (op == 4'h0) begin
            n_checks++;
            if (instr_req !== 1'b1 || acc_we !== 1'b0) begin
                n_fail++; $display("FAIL nop_return req=%b we=%b want req=1 we=0", instr_req, acc_we);
            end
            return;
        end
        if (op == 4'hF) begin
            n_checks++;
            if (halt !== 1'b1 || instr_req !== 1'b0 || acc_we !== 1'b0) begin
                n_fail++; $display("FAIL halt_entry halt=%b req=%b we=%b want 1 0 0", halt, instr_req, acc_we);
            end
            return;
        end
        if (op == 4'h2) begin
            for (int i = 0; i < dwait; i++) begin
                data_valid = 1'b0; in_valid = 1'($urandom % 2); instr_valid = 1'($urandom % 2);
                step();
                n_checks++;
                if (data_req !== 1'b1 || data_addr !== w[7:0] || acc_we !== 1'b0 || asel0 !== m_asel0) begin
                    n_fail++; $display("FAIL mem_wait req=%b addr=%h we=%b asel0=%0d want 1 %h 0 %0d", data_req, data_addr, acc_we, asel0, w[7:0], m_asel0);
                end
            end
            instr_valid = 1'b0; in_valid = 1'b0; data_valid = 1'b1;
            #1;
            n_checks++;
            if (data_req !== 1'b1 || data_addr !== w[7:0]) begin
                n_fail++; $display("FAIL mem_accept req=%b addr=%h want 1 %h", data_req, data_addr, w[7:0]);
            end
            step();
            data_valid = 1'b0;
        end
        if (op == 4'h8) begin
            for (int i = 0; i < inwait; i++) begin
                in_valid = 1'b0; data_valid = 1'($urandom % 2); instr_valid = 1'($urandom % 2);
                #1;
                n_checks++;
                if (in_ack !== 1'b0 || acc_we !== 1'b0) begin
                    n_fail++; $display("FAIL in_wait ack=%b we=%b want 0 0", in_ack, acc_we);
                end
                step();
            end
            instr_valid = 1'b0; data_valid = 1'b0; in_valid = 1'b1;
            #1;
            n_checks++;
            if (in_ack !== 1'b1) begin
                n_fail++; $display("FAIL in_ack got=%b want=1", in_ack);
            end
            step();
            in_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (acc_we !== 1'b1 || asel0 !== m_asel0 || asel1 !== m_asel1 || acc_src !== m_src || in_ack !== 1'b0 || data_req !== 1'b0) begin
            n_fail++;
            $display("FAIL exec op=%h we=%b asel0=%0d asel1=%0d src=%b ack=%b dreq=%b want we=1 asel0=%0d asel1=%0d src=%b ack=0 dreq=0",
                     op, acc_we, asel0, asel1, acc_src, in_ack, data_req, m_asel0, m_asel1, m_src);
        end
        step();
        n_checks++;
        if (acc_we !== 1'b0 || instr_req !== 1'b1) begin
            n_fail++; $display("FAIL exec_end we=%b req=%b want we=0 req=1", acc_we, instr_req);
        end
    endtask

    task automatic test_ldi();
        run_instr(16'h3A5C, 0, 0, 0);
    endtask

    task automatic test_inc();
        run_instr(16'hA000, 0, 0, 0);
    endtask

    task automatic test_ldm();
        run_instr(16'h2042, 0, 3, 0);
    endtask

    task automatic test_in();
        run_instr(16'h8000, 0, 0, 2);
    endtask

    task automatic test_random_program();
        logic [15:0] w;
        while (m_pc != 8'hFF) begin
            w = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_instr({4'($urandom_range(1, 14)), 12'($urandom)}, 0, 0, 0);
    endtask

    task automatic test_wrap_halt();
        run_instr(16'h0000, 0, 0, 0);
        n_checks++;
        if (instr_addr !== 8'h00) begin
            n_fail++; $display("FAIL pc_wrap addr=%h want=00", instr_addr);
        end
        run_instr(16'hF000, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'($urandom % 2); instr_rdata = 16'h3055;
            data_valid = 1'($urandom % 2); in_valid = 1'($urandom % 2);
            step();
            n_checks++;
            if (halt !== 1'b1 || instr_req !== 1'b0 || acc_we !== 1'b0 || in_ack !== 1'b0 || data_req !== 1'b0 || instr_addr !== m_pc) begin
                n_fail++;
                $display("FAIL halt_hold halt=%b req=%b we=%b ack=%b dreq=%b addr=%h want 1 0 0 0 0 %h",
                         halt, instr_req, acc_we, in_ack, data_req, instr_addr, m_pc);
            end
        end
        instr_valid = 1'b0; data_valid = 1'b0; in_valid = 1'b0;
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        run_instr(16'h5000, 0, 0, 0);
        instr_valid = 1'b1; instr_rdata = 16'h2042;
        step();
        instr_valid = 1'b0;
        step();
        n_checks++;
        if (data_req !== 1'b1 || data_addr !== 8'h42) begin
            n_fail++; $display("FAIL mid_mem_setup dreq=%b addr=%h want 1 42", data_req, data_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_req !== 1'b0 || acc_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_mem_rst dreq=%b we=%b want 0 0", data_req, acc_we);
        end
        step();
        rst = 1'b0;
        m_pc = 8'h00; m_asel0 = 3'd0; m_asel1 = 3'd0; m_src = 1'b0;
        #1;
        n_checks++;
        if (data_req !== 1'b0 || instr_req !== 1'b1 || instr_addr !== 8'h00 || acc_we !== 1'b0 || asel0 !== 3'd0) begin
            n_fail++; $display("FAIL post_rst dreq=%b req=%b addr=%h we=%b asel0=%0d want 0 1 00 0 0", data_req, instr_req, instr_addr, acc_we, asel0);
        end
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            step();
            n_checks++;
            if (data_req !== 1'b0 || acc_we !== 1'b0 || instr_req !== 1'b1 || instr_addr !== 8'h00) begin
                n_fail++; $display("FAIL stray_data dreq=%b we=%b req=%b addr=%h want 0 0 1 00", data_req, acc_we, instr_req, instr_addr);
            end
        end
        data_valid = 1'b0;
        run_instr(16'h9000, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_rdata = 16'h0000; data_valid = 1'b0; in_valid = 1'b0;
        step();
        test_reset();
        test_ldi();
        test_inc();
        test_ldm();
        test_in();
        test_back_to_back();
        test_random_program();
        test_wrap_halt();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
Control sequencer for the 16-bit accumulator datapath: fetches 16-bit instruction words, decodes them and drives the ALU operand/operation selects (asel0/asel1), the 8-bit immediate and the accumulator write strobe. It is the controlling end of the ALU select interface. It also handles the instruction-memory, data-memory and input-port handshakes.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
instr_req  out  1  instruction fetch request
instr_addr  out  PC_W  fetch address (= pc)
instr_valid  in  1  instruction word present; accepted only while instr_req=1
instr_rdata  in  16  instruction word
data_req  out  1  data-memory read request (LDM)
data_addr  out  8  data read address (= ir[7:0])
data_valid  in  1  data word present; accepted only while data_req=1
in_valid  in  1  external input word valid (IN)
in_ack  out  1  one-cycle acknowledge of input word
asel0  out  3  ALU out1 select
asel1  out  3  ALU out2 select
acc_src  out  1  accumulator source: 0=out1, 1=out2
acc_we  out  1  accumulator write strobe, one cycle
imm  out  8  immediate / address field (= ir[7:0])
reg_sel  out  4  register-file read index (= ir[11:8])
halt  out  1  processor halted

Behaviour:
- Instruction format: ir[15:12] opcode, ir[11:8] reg_sel, ir[7:0] imm.
- Opcodes: 0 NOP; 1 LDR asel0=000; 2 LDM asel0=001; 3 LDI asel0=010; 4 AND 011; 5 OR 100; 6 ADD 101; 7 SUB 110; 8 IN asel0=111; all of these set acc_src=0. 9 NOT asel1=000; A INC 001; B DEC 010; C SHL 011; D SHR 100; E ROR 101; these set acc_src=1. F HLT.
- States: FETCH, DECODE, MEM, WAIT_IN, EXEC, HALT.
- Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, ir=0, asel0=0, asel1=0, acc_src=0, halt=0. While rst=1, instr_req, data_req, in_ack and acc_we are forced to 0.
- FETCH: instr_req=1. On instr_valid: ir<=instr_rdata, pc<=pc+1 (wraps at 2^PC_W-1 -> 0), go to DECODE. Otherwise hold.
- DECODE (1 cycle): asel0, asel1 and acc_src are registered from the opcode. Unused select fields keep their previous value. Next state by opcode: NOP->FETCH; LDM->MEM; IN->WAIT_IN; HLT->HALT; all others->EXEC.
- MEM: data_req=1, data_addr=ir[7:0]. On data_valid go to EXEC; otherwise hold.
- WAIT_IN: when in_valid=1, in_ack=1 combinationally in that same cycle and the state goes to EXEC. Otherwise hold, with in_ack=0.
- EXEC: acc_we=1 for exactly one cycle, then go to FETCH.
- HALT: halt=1 and all strobes 0. Only rst leaves this state.
- Strobe outputs are decoded from the state; select outputs are registered. asel0/asel1/acc_src hold stable from the end of DECODE through EXEC.
- Latency with 0-wait handshakes: ALU op/NOP = 3/2 cycles; LDM and IN = 4 cycles.
- Boundary conditions:
  - instr_valid, data_valid and in_valid are ignored outside their own state.
  - A valid input asserted in the same cycle the state is entered is accepted that cycle.
  - Reset in any state, including mid-handshake, abandons the operation; no acc_we is issued.
  - HLT does not increment pc beyond the fetch increment.

Test Plan:
1. Reset, then fetch 0x3A5C with instr_valid tied high -> instr_addr=0. Next cycle DECODE; then EXEC with asel0=010, imm=0x5C, reg_sel=0xA, acc_src=0, acc_we pulses once. pc=1.
2. Fetch 0xA000 (INC) -> asel1=001, acc_src=1, acc_we one cycle. asel0 keeps its previous value.
3. Fetch 0x2042 (LDM) with data_valid delayed 3 cycles -> data_req=1 and data_addr=0x42 held for 3 cycles. acc_we pulses 1 cycle after data_valid with asel0=001.
4. Fetch 0x8000 (IN) with in_valid asserted 2 cycles later -> in_ack is a single pulse coincident with in_valid, followed by acc_we with asel0=111.
5. pc=0xFF, fetch a NOP -> pc wraps to 0x00 and acc_we is never asserted. Then fetch 0xF000 -> halt=1. Further instr_valid pulses are ignored and halt stays 1 until rst.
6. Assert rst while in MEM with data_req=1 -> next cycle data_req=0, state=FETCH, pc=RESET_PC, no acc_we. A stray data_valid afterwards has no effect.
